display_scan_ctrl: RTL



---
 rtl/display_scan_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
// Sequencing controller for the two shared-segment 7-segment displays that
// show the corrected Hamming word (digit 0) and its syndrome (digit 1).
// The push-button is synchronised and debounced. Each clean press advances
// the display mode MAN_BIN -> MAN_SIN -> AUTO -> MAN_BIN. In AUTO both digits
// are time-multiplexed, with a blanking gap between them to suppress ghosting.
//
// Ports
//   clk      in   1  system clock
//   rst      in   1  asynchronous, active-high reset
//   btn_raw  in   1  unsynchronised push-button, high when pressed
//   seg_bin  in   7  decoded segments for the corrected 4-bit word
//   seg_sin  in   7  decoded segments for the 3-bit syndrome
//   seg      out  7  registered segment bus shared by both displays
//   an       out  2  registered anode enables, active-high
//                    (bit0 = word digit, bit1 = syndrome digit)
//   mode     out  2  00 MAN_BIN, 01 MAN_SIN, 10 AUTO
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
   parameter int         DEB_CYCLES     = 500000,
   parameter int         REFRESH_CYCLES = 50000,
   parameter int         BLANK_CYCLES   = 500,
   parameter logic [6:0] SEG_BLANK      = 7'h7F
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_raw,
   input  logic [6:0] seg_bin,
   input  logic [6:0] seg_sin,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic [1:0] mode
);

   typedef enum logic [1:0] {
      MAN_BIN = 2'b00,
      MAN_SIN = 2'b01,
      AUTO    = 2'b10
   } mode_e;

   typedef enum logic [1:0] {
      DIG0   = 2'b00,
      BLANK0 = 2'b01,
      DIG1   = 2'b10,
      BLANK1 = 2'b11
   } scan_e;

   localparam int DEB_MAX = (DEB_CYCLES < 2) ? 2 : DEB_CYCLES;
   localparam int DEB_W   = $clog2(DEB_MAX);

   // One phase counter serves both lit and blank phases, so it is sized for
   // the longer of the two.
   localparam int PH_RAW = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
   localparam int PH_MAX = (PH_RAW < 2) ? 2 : PH_RAW;
   localparam int PH_W   = $clog2(PH_MAX);

   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
   localparam logic [PH_W-1:0]  REF_LAST = PH_W'(REFRESH_CYCLES - 1);
   localparam logic [PH_W-1:0]  BLK_LAST = PH_W'(BLANK_CYCLES - 1);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic             s1_q, s2_q;
   logic             btn_db_q, btn_db_d;
   logic             btn_db_dly_q;
   logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
   mode_e            mode_q, mode_d;
   scan_e            scan_q, scan_d;
   logic [PH_W-1:0]  ph_cnt_q, ph_cnt_d;
   logic [6:0]       seg_q, seg_d;
   logic [1:0]       an_q, an_d;
   logic             press;
   logic [PH_W-1:0]  ph_last;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q         <= 1'b0;
         s2_q         <= 1'b0;
         btn_db_q     <= 1'b0;
         btn_db_dly_q <= 1'b0;
         deb_cnt_q    <= '0;
         mode_q       <= MAN_BIN;
         scan_q       <= DIG0;
         ph_cnt_q     <= '0;
         seg_q        <= SEG_BLANK;
         an_q         <= 2'b00;
      end else begin
         s1_q         <= btn_raw;
         s2_q         <= s1_q;
         btn_db_q     <= btn_db_d;
         btn_db_dly_q <= btn_db_q;
         deb_cnt_q    <= deb_cnt_d;
         mode_q       <= mode_d;
         scan_q       <= scan_d;
         ph_cnt_q     <= ph_cnt_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
      end
   end

   // ---------------------------------------------------------------------
   // Debouncer: the synchronised level must disagree with the debounced
   // level for DEB_CYCLES consecutive samples; any agreeing sample restarts.
   // ---------------------------------------------------------------------
   // NOTE: every combinational output gets a default before any branch, so no
   // path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      deb_cnt_d = '0;
      btn_db_d  = btn_db_q;
      if (s2_q != btn_db_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            btn_db_d = s2_q;
         end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
         end
      end
   end

   // Rising edge of the debounced level only; a held button yields one press.
   assign press = btn_db_q & ~btn_db_dly_q;

   // ---------------------------------------------------------------------
   // Mode FSM
   // ---------------------------------------------------------------------
   always_comb begin
      mode_d = mode_q;
      if (press) begin
         case (mode_q)
            MAN_BIN: mode_d = MAN_SIN;
            MAN_SIN: mode_d = AUTO;
            default: mode_d = MAN_BIN;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Scan FSM. Held at DIG0/0 outside AUTO and on the press that leaves AUTO,
   // so every entry into AUTO begins with a full-length DIG0 phase.
   // ---------------------------------------------------------------------
   assign ph_last = (scan_q == DIG0 || scan_q == DIG1) ? REF_LAST : BLK_LAST;

   always_comb begin
      scan_d   = DIG0;
      ph_cnt_d = '0;
      if (mode_q == AUTO && !press) begin
         if (ph_cnt_q == ph_last) begin
            case (scan_q)
               DIG0:    scan_d = BLANK0;
               BLANK0:  scan_d = DIG1;
               DIG1:    scan_d = BLANK1;
               default: scan_d = DIG0;
            endcase
         end else begin
            scan_d   = scan_q;
            ph_cnt_d = ph_cnt_q + PH_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Output register. Whenever AUTO is being entered, held or left, the
   // next scan state drives the pins: entry shows DIG0 on the same edge mode
   // reads AUTO, and exit shows DIG0 (identical to MAN_BIN) so there is no
   // blank gap. Manual modes follow the registered mode one cycle later.
   // ---------------------------------------------------------------------
   always_comb begin
      an_d  = 2'b00;
      seg_d = SEG_BLANK;
      if (mode_q == AUTO || mode_d == AUTO) begin
         case (scan_d)
            DIG0: begin
               an_d  = 2'b01;
               seg_d = seg_bin;
            end
            DIG1: begin
               an_d  = 2'b10;
               seg_d = seg_sin;
            end
            default: begin
               an_d  = 2'b00;
               seg_d = SEG_BLANK;
            end
         endcase
      end else begin
         case (mode_q)
            MAN_BIN: begin
               an_d  = 2'b01;
               seg_d = seg_bin;
            end
            MAN_SIN: begin
               an_d  = 2'b10;
               seg_d = seg_sin;
            end
            default: begin
               an_d  = 2'b00;
               seg_d = SEG_BLANK;
            end
         endcase
      end
   end

   assign seg  = seg_q;
   assign an   = an_q;
   assign mode = mode_q;

endmodule
